// File: rtl/tlb_front_pkg.sv
// Shared types for the TLB front end: page-number widths, entry layout and
// the miss-handling state encoding.
package tlb_front_pkg;

    localparam int VPN_W = 20;
    localparam int PPN_W = 20;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] tag;
        logic [PPN_W-1:0] ppn;
        logic             user;
        logic             exec;
        logic             write;
        logic             cache;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_RESP = 2'd2
    } tlb_state_t;

    // Builds a valid entry from a completed page walk.
    function automatic tlb_entry_t make_entry(
        input logic [VPN_W-1:0] tag,
        input logic [PPN_W-1:0] ppn,
        input logic             user,
        input logic             exec,
        input logic             write,
        input logic             cache
    );
        tlb_entry_t e;
        e.valid = 1'b1;
        e.tag   = tag;
        e.ppn   = ppn;
        e.user  = user;
        e.exec  = exec;
        e.write = write;
        e.cache = cache;
        return e;
    endfunction

endpackage

// File: rtl/tlb_front_if.sv
// Requester and MMU-walk signals of the TLB front end; slave is the TLB's view,
// master is the environment (requester plus page-walk unit).
interface tlb_front_if;
    import tlb_front_pkg::*;

    logic             req;
    logic [VPN_W-1:0] vpn;
    logic [VPN_W-1:0] pdb_addr;
    logic             flush;
    logic             stall;
    logic [PPN_W-1:0] ppn;
    logic             page_fault;
    logic             auth_user;
    logic             auth_exec;
    logic             auth_write;
    logic             en_cache;
    logic             mmu_en;
    logic [VPN_W-1:0] mmu_logical;
    logic [VPN_W-1:0] mmu_pdb;
    logic             mmu_stall;
    logic [PPN_W-1:0] mmu_physical;
    logic             mmu_page_fault;
    logic             mmu_auth_user;
    logic             mmu_auth_exec;
    logic             mmu_auth_write;
    logic             mmu_en_cache;

    modport slave (
        input  req, vpn, pdb_addr, flush,
        input  mmu_stall, mmu_physical, mmu_page_fault,
        input  mmu_auth_user, mmu_auth_exec, mmu_auth_write, mmu_en_cache,
        output stall, ppn, page_fault, auth_user, auth_exec, auth_write, en_cache,
        output mmu_en, mmu_logical, mmu_pdb
    );

    modport master (
        output req, vpn, pdb_addr, flush,
        output mmu_stall, mmu_physical, mmu_page_fault,
        output mmu_auth_user, mmu_auth_exec, mmu_auth_write, mmu_en_cache,
        input  stall, ppn, page_fault, auth_user, auth_exec, auth_write, en_cache,
        input  mmu_en, mmu_logical, mmu_pdb
    );

endinterface

// File: rtl/tlb_front_cam.sv
// Tag-compare array: one-hot match reduced to hit flag and index, plus the
// lowest-index free slot used as the preferred install victim.
module tlb_front_cam
    import tlb_front_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic [VPN_W-1:0]              vpn,
    input  logic [ENTRIES-1:0]            valid,
    input  logic [ENTRIES-1:0][VPN_W-1:0] tags,
    output logic                          hit,
    output logic [IDX_W-1:0]              hit_idx,
    output logic                          any_invalid,
    output logic [IDX_W-1:0]              free_idx
);

    logic [ENTRIES-1:0] hit_vec_s;

    // Match vector; the install path never creates duplicates, so OR-encoding is exact.
    always_comb begin
        hit_vec_s = '0;
        hit_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_vec_s[i] = valid[i] && (tags[i] == vpn);
            hit_idx      = hit_idx | ({IDX_W{hit_vec_s[i]}} & IDX_W'(i));
        end
        hit = |hit_vec_s;
    end

    // Lowest-index invalid entry: scan downward so the last write wins.
    always_comb begin
        free_idx    = '0;
        any_invalid = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            free_idx    = valid[i] ? free_idx : IDX_W'(i);
            any_invalid = any_invalid | ~valid[i];
        end
    end

endmodule

// File: rtl/tlb_front.sv
// Fully-associative TLB in front of the MMU page walker: same-cycle hits,
// walk-and-install on a miss, round-robin replacement once full.
module tlb_front
    import tlb_front_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input logic        clk,
    input logic        rst,
    tlb_front_if.slave bus
);

    tlb_entry_t       entries_r [ENTRIES];
    tlb_state_t       state_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [VPN_W-1:0] vpn_lat_r;
    logic [VPN_W-1:0] pdb_lat_r;
    logic [PPN_W-1:0] res_ppn_r;
    logic [3:0]       res_flags_r;
    logic             res_fault_r;
    logic             flush_pending_r;

    logic [ENTRIES-1:0]            valid_s;
    logic [ENTRIES-1:0][VPN_W-1:0] tags_s;
    logic                          hit_s;
    logic [IDX_W-1:0]              hit_idx_s;
    logic                          any_invalid_s;
    logic [IDX_W-1:0]              free_idx_s;
    tlb_entry_t                    hit_entry_s;
    tlb_entry_t                    walk_entry_s;
    logic                          walk_done_s;
    logic                          install_s;
    logic [IDX_W-1:0]              victim_s;

    logic             stall_s;
    logic [PPN_W-1:0] ppn_s;
    logic             fault_s;
    logic [3:0]       flags_s;

    // Flatten the entry array for the compare block.
    always_comb begin
        valid_s = '0;
        tags_s  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_s[i] = entries_r[i].valid;
            tags_s[i]  = entries_r[i].tag;
        end
    end

    tlb_front_cam #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_cam (
        .vpn         (bus.vpn),
        .valid       (valid_s),
        .tags        (tags_s),
        .hit         (hit_s),
        .hit_idx     (hit_idx_s),
        .any_invalid (any_invalid_s),
        .free_idx    (free_idx_s)
    );

    assign hit_entry_s  = entries_r[hit_idx_s];
    assign walk_entry_s = make_entry(vpn_lat_r, bus.mmu_physical, bus.mmu_auth_user,
                                     bus.mmu_auth_exec, bus.mmu_auth_write, bus.mmu_en_cache);
    assign walk_done_s  = (state_r == ST_WALK) && !bus.mmu_stall;
    // A flush seen at any point of the walk, including its last cycle, blocks the install.
    assign install_s    = walk_done_s && !bus.mmu_page_fault && !flush_pending_r && !bus.flush;
    assign victim_s     = any_invalid_s ? free_idx_s : rr_ptr_r;

    // Miss FSM, walk-result capture, replacement pointer and entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            rr_ptr_r        <= '0;
            vpn_lat_r       <= '0;
            pdb_lat_r       <= '0;
            res_ppn_r       <= '0;
            res_flags_r     <= 4'b0000;
            res_fault_r     <= 1'b0;
            flush_pending_r <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req && !hit_s) begin
                        vpn_lat_r <= bus.vpn;
                        pdb_lat_r <= bus.pdb_addr;
                        state_r   <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (bus.flush) begin
                        flush_pending_r <= 1'b1;
                    end
                    if (walk_done_s) begin
                        res_ppn_r   <= bus.mmu_physical;
                        res_flags_r <= {bus.mmu_auth_user, bus.mmu_auth_exec,
                                        bus.mmu_auth_write, bus.mmu_en_cache};
                        res_fault_r <= bus.mmu_page_fault;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    flush_pending_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
                default: begin
                    flush_pending_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase

            if (bus.flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    entries_r[i].valid <= 1'b0;
                end
            end else if (install_s) begin
                entries_r[victim_s] <= walk_entry_s;
            end

            if (install_s && !any_invalid_s) begin
                rr_ptr_r <= rr_ptr_r + IDX_W'(1);
            end
        end
    end

    // Requester-side response: hits answer in the request cycle, misses in RESP.
    always_comb begin
        stall_s = 1'b0;
        ppn_s   = '0;
        fault_s = 1'b0;
        flags_s = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                if (bus.req && hit_s) begin
                    ppn_s   = hit_entry_s.ppn;
                    flags_s = {hit_entry_s.user, hit_entry_s.exec,
                               hit_entry_s.write, hit_entry_s.cache};
                end else begin
                    stall_s = bus.req;
                end
            end
            ST_WALK: begin
                stall_s = 1'b1;
            end
            ST_RESP: begin
                ppn_s   = res_ppn_r;
                fault_s = res_fault_r;
                flags_s = res_flags_r;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    assign bus.stall       = stall_s;
    assign bus.ppn         = ppn_s;
    assign bus.page_fault  = fault_s;
    assign bus.auth_user   = flags_s[3];
    assign bus.auth_exec   = flags_s[2];
    assign bus.auth_write  = flags_s[1];
    assign bus.en_cache    = flags_s[0];
    assign bus.mmu_en      = (state_r == ST_WALK);
    assign bus.mmu_logical = (state_r == ST_WALK) ? vpn_lat_r : '0;
    assign bus.mmu_pdb     = (state_r == ST_WALK) ? pdb_lat_r : '0;

endmodule

// File: tb/tb_tlb_front.sv
// Directed bench for tlb_front: the MMU walker is modelled by the tasks, which
// drive each walk's busy length and result and check the TLB's responses.
module tb_tlb_front;
    import tlb_front_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    tlb_front_if bus();

    tlb_front #(.ENTRIES(8), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req            = 1'b0;
        bus.vpn            = 20'h0;
        bus.pdb_addr       = 20'h0;
        bus.flush          = 1'b0;
        bus.mmu_stall      = 1'b1;
        bus.mmu_physical   = 20'h0;
        bus.mmu_page_fault = 1'b0;
        bus.mmu_auth_user  = 1'b0;
        bus.mmu_auth_exec  = 1'b0;
        bus.mmu_auth_write = 1'b0;
        bus.mmu_en_cache   = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        rst = 1'b1;
        idle_inputs();
        #1;
        ctl = {bus.stall, bus.mmu_en, bus.page_fault, bus.auth_user,
               bus.auth_exec, bus.auth_write, bus.en_cache};
        vec_cnt++;
        if (ctl !== 7'b0) begin
            err_cnt++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0);
        end
        vec_cnt++;
        if ({bus.ppn, bus.mmu_logical, bus.mmu_pdb} !== 60'h0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", bus.ppn, bus.mmu_logical, bus.mmu_pdb);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Full miss: request, walk of busy+1 mmu_en cycles, RESP check, then idle check.
    task automatic run_miss(input logic [19:0] v, input int busy, input logic [19:0] phys,
                            input logic flt, input logic [3:0] fl, input int flush_at,
                            input string nm);
        int         cyc;
        logic [19:0] pdb;
        pdb = v ^ 20'hA5A5A;
        @(negedge clk);
        bus.req      = 1'b1;
        bus.vpn      = v;
        bus.pdb_addr = pdb;
        #1;
        vec_cnt++;
        if (bus.stall !== 1'b1 || bus.mmu_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_req: stall=%b mmu_en=%b expected 1/0", nm, bus.stall, bus.mmu_en);
        end
        @(posedge clk);
        cyc = 0;
        forever begin
            @(negedge clk);
            bus.flush = 1'b0;
            #1;
            if (!bus.mmu_en) break;
            cyc++;
            if (cyc > 40) begin
                err_cnt++;
                $display("FAIL %s_timeout: walk still active after %0d cycles", nm, cyc);
                break;
            end
            if (cyc == 1) begin
                vec_cnt++;
                if (bus.mmu_logical !== v || bus.mmu_pdb !== pdb || bus.stall !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL %s_walk: logical=%h pdb=%h stall=%b expected %h/%h/1",
                             nm, bus.mmu_logical, bus.mmu_pdb, bus.stall, v, pdb);
                end
            end
            bus.mmu_stall      = (cyc <= busy);
            bus.mmu_physical   = phys;
            bus.mmu_page_fault = flt;
            {bus.mmu_auth_user, bus.mmu_auth_exec, bus.mmu_auth_write, bus.mmu_en_cache} = fl;
            bus.flush = (cyc == flush_at);
            @(posedge clk);
        end
        bus.mmu_stall = 1'b1;
        vec_cnt++;
        if (cyc !== busy + 1) begin
            err_cnt++;
            $display("FAIL %s_en_cycles: got %0d expected %0d", nm, cyc, busy + 1);
        end
        vec_cnt++;
        if (bus.stall !== 1'b0 || bus.ppn !== phys || bus.page_fault !== flt ||
            {bus.auth_user, bus.auth_exec, bus.auth_write, bus.en_cache} !== fl) begin
            err_cnt++;
            $display("FAIL %s_resp: stall=%b ppn=%h pf=%b flags=%b expected 0/%h/%b/%b",
                     nm, bus.stall, bus.ppn, bus.page_fault,
                     {bus.auth_user, bus.auth_exec, bus.auth_write, bus.en_cache}, phys, flt, fl);
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        #1;
        vec_cnt++;
        if (bus.stall !== 1'b0 || bus.page_fault !== 1'b0 || bus.mmu_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_after: stall=%b pf=%b mmu_en=%b expected 0/0/0",
                     nm, bus.stall, bus.page_fault, bus.mmu_en);
        end
    endtask

    // Single-cycle lookup probe; a miss is withdrawn before the edge so no walk starts.
    task automatic check_hit(input logic [19:0] v, input logic exp_hit,
                             input logic [19:0] exp_ppn, input string nm);
        @(negedge clk);
        bus.req = 1'b1;
        bus.vpn = v;
        #1;
        vec_cnt++;
        if (bus.stall !== ~exp_hit || bus.mmu_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_hit: stall=%b mmu_en=%b expected %b/0", nm, bus.stall, bus.mmu_en, ~exp_hit);
        end
        if (exp_hit) begin
            vec_cnt++;
            if (bus.ppn !== exp_ppn || bus.page_fault !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s_ppn: got %h pf=%b expected %h pf=0", nm, bus.ppn, bus.page_fault, exp_ppn);
            end
        end
        bus.req = 1'b0;
    endtask

    task automatic test_cold_miss_and_hit();
        run_miss(20'h12345, 3, 20'h0ABCD, 1'b0, 4'b1011, 0, "cold");
        check_hit(20'h12345, 1'b1, 20'h0ABCD, "hit");
        check_hit(20'h12346, 1'b0, 20'h0, "near_miss");
    endtask

    task automatic test_fault();
        run_miss(20'h00001, 1, 20'h00777, 1'b1, 4'b1111, 0, "fault");
        check_hit(20'h00001, 1'b0, 20'h0, "fault_not_installed");
        run_miss(20'h00001, 0, 20'h00888, 1'b0, 4'b0000, 0, "fault_rewalk");
        check_hit(20'h00001, 1'b1, 20'h00888, "rewalk_hit");
    endtask

    task automatic test_replacement();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_hit(20'h12345, 1'b0, 20'h0, "flushed");
        for (int i = 0; i < 8; i++) begin
            run_miss(20'h00100 + 20'(i), 0, 20'h05000 + 20'(i), 1'b0, 4'b1001, 0, "fill");
        end
        run_miss(20'h00108, 0, 20'h05008, 1'b0, 4'b0101, 0, "evict0");
        check_hit(20'h00100, 1'b0, 20'h0, "victim_gone");
        check_hit(20'h00101, 1'b1, 20'h05001, "e1_kept");
        check_hit(20'h00108, 1'b1, 20'h05008, "new_entry");
        check_hit(20'h00107, 1'b1, 20'h05007, "e7_kept");
        run_miss(20'h00109, 2, 20'h05009, 1'b0, 4'b0011, 0, "evict1");
        check_hit(20'h00101, 1'b0, 20'h0, "rr_advanced");
        check_hit(20'h00102, 1'b1, 20'h05002, "e2_kept");
    endtask

    task automatic test_flush();
        run_miss(20'h00200, 3, 20'h06200, 1'b0, 4'b0110, 2, "flush_walk");
        check_hit(20'h00108, 1'b0, 20'h0, "flush_cleared");
        check_hit(20'h00200, 1'b0, 20'h0, "flush_not_installed");
        run_miss(20'h00200, 1, 20'h06201, 1'b0, 4'b1000, 0, "after_flush");
        check_hit(20'h00200, 1'b1, 20'h06201, "pending_cleared");
        // Flush alongside a hit: the lookup still sees the old contents.
        @(negedge clk);
        bus.req   = 1'b1;
        bus.vpn   = 20'h00200;
        bus.flush = 1'b1;
        #1;
        vec_cnt++;
        if (bus.stall !== 1'b0 || bus.ppn !== 20'h06201) begin
            err_cnt++;
            $display("FAIL flush_idle_hit: stall=%b ppn=%h expected 0/06201", bus.stall, bus.ppn);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.req   = 1'b0;
        check_hit(20'h00200, 1'b0, 20'h0, "flush_idle_after");
    endtask

    task automatic test_async_reset();
        run_miss(20'h00400, 0, 20'h07400, 1'b0, 4'b1111, 0, "pre_reset");
        @(negedge clk);
        bus.req      = 1'b1;
        bus.vpn      = 20'h00500;
        bus.pdb_addr = 20'h00001;
        @(posedge clk);
        @(negedge clk);
        bus.mmu_stall = 1'b1;
        #1;
        vec_cnt++;
        if (bus.mmu_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_walk_started: mmu_en=%b expected 1", bus.mmu_en);
        end
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (bus.mmu_en !== 1'b0 || bus.stall !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_async_drop: mmu_en=%b stall=%b expected 0/1", bus.mmu_en, bus.stall);
        end
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_hit(20'h00400, 1'b0, 20'h0, "rst_cleared");
        check_hit(20'h00500, 1'b0, 20'h0, "rst_no_install");
        run_miss(20'h00500, 1, 20'h07500, 1'b0, 4'b0010, 0, "post_reset");
        check_hit(20'h00500, 1'b1, 20'h07500, "post_reset_hit");
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_fault();
        test_replacement();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
